// File: rtl/key_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : key_pkg                                                      |
// | Description : Shared definitions for the key-handling blocks: gesture FSM  |
// |               state encoding and default timing constants (50 MHz clock).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package key_pkg;

  // Gesture FSM state encoding
  typedef logic [2:0] key_state_t;

  localparam key_state_t IDLE           = 3'd0;
  localparam key_state_t PRESSED        = 3'd1;
  localparam key_state_t LONG_HELD      = 3'd2;
  localparam key_state_t WAIT_SECOND    = 3'd3;
  localparam key_state_t SECOND_PRESSED = 3'd4;

  // Default timing, in clk cycles at 50 MHz
  localparam int KEY_LONG_CYC_DEF   = 75000000;  // 1.5 s hold
  localparam int KEY_DBL_CYC_DEF    = 15000000;  // 300 ms release-to-press gap
  localparam int KEY_REPEAT_CYC_DEF = 10000000;  // 200 ms auto-repeat period
  localparam int KEY_CNT_W_DEF      = 27;        // holds the largest count - 1

endpackage
`default_nettype wire

// File: rtl/key_press_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : key_press_decoder_if                                         |
// | Description : Event inputs and gesture result outputs of the key press     |
// |               decoder.                                                     |
// |   in_key_down      : one-cycle pulse, key pressed                          |
// |   in_key_up        : one-cycle pulse, key released                         |
// |   out_short_press  : one-cycle pulse, single short press confirmed         |
// |   out_long_press   : one-cycle pulse, hold reached the long threshold      |
// |   out_double_click : one-cycle pulse, second press released                |
// |   out_repeat       : one-cycle auto-repeat pulse while long-held           |
// |   out_busy         : level, a gesture is in progress                       |
// |   Modports: master (event source / result consumer), slave (decoder).      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface key_press_decoder_if;

  logic in_key_down;
  logic in_key_up;
  logic out_short_press;
  logic out_long_press;
  logic out_double_click;
  logic out_repeat;
  logic out_busy;

  modport master (
    output in_key_down,
    output in_key_up,
    input  out_short_press,
    input  out_long_press,
    input  out_double_click,
    input  out_repeat,
    input  out_busy
  );

  modport slave (
    input  in_key_down,
    input  in_key_up,
    output out_short_press,
    output out_long_press,
    output out_double_click,
    output out_repeat,
    output out_busy
  );

endinterface
`default_nettype wire

// File: rtl/key_press_decoder_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : key_gesture_timer                                            |
// | Description : CNT_W-bit gesture timer with synchronous clear, count enable |
// |               and a terminal compare against a run-time limit.           |
// |   clk   : system clock                                                     |
// |   rst_n : asynchronous active-low reset                                    |
// |   clr   : clear count to 0 (dominates en)                                  |
// |   en    : increment count                                                  |
// |   limit : terminal value                                                   |
// |   term  : count equals limit (combinational)                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module key_gesture_timer #(
  parameter int CNT_W = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             term
);

  logic [CNT_W-1:0] cnt_r;

  // The controller never enables counting past the terminal value, so the
  // counter cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign term = (cnt_r == limit);

endmodule
`default_nettype wire

// File: rtl/key_press_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : key_press_decoder                                            |
// | Description : Classifies clean key_down/key_up pulses into short press,    |
// |               long press and double click gestures; all results are      |
// |               registered one-cycle pulses.                                 |
// |   clk   : system clock, rising edge                                        |
// |   rst_n : asynchronous active-low reset                                    |
// |   bus   : key_press_decoder_if.slave (events in, gesture pulses out)       |
// | Options     : KEY_REPEAT_EN - periodic out_repeat pulses while long-held;  |
// |               when undefined out_repeat is tied to 0.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module key_press_decoder
  import key_pkg::*;
#(
  parameter int LONG_CYC   = KEY_LONG_CYC_DEF,
  parameter int DBL_CYC    = KEY_DBL_CYC_DEF,
  parameter int REPEAT_CYC = KEY_REPEAT_CYC_DEF,
  parameter int CNT_W      = KEY_CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  key_press_decoder_if.slave bus
);

  localparam logic [CNT_W-1:0] LONG_LIM   = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_LIM    = CNT_W'(DBL_CYC - 1);
  localparam logic [CNT_W-1:0] REPEAT_LIM = CNT_W'(REPEAT_CYC - 1);

  key_state_t       state;
  key_state_t       state_nxt;

  logic             down;
  logic             up;
  logic             term;
  logic             tmr_clr;
  logic             tmr_en;
  logic [CNT_W-1:0] tmr_limit;

  logic             short_nxt;
  logic             long_nxt;
  logic             dbl_nxt;
  logic             short_r;
  logic             long_r;
  logic             dbl_r;
  logic             busy_r;

  // Simultaneous down and up is treated as no event at all.
  assign down = bus.in_key_down & ~bus.in_key_up;
  assign up   = bus.in_key_up   & ~bus.in_key_down;

  // ---------------------------------------------------------------------------
  // Gesture timer; the limit follows the state that is timing.
  // ---------------------------------------------------------------------------
  always_comb begin
    tmr_limit = '0;
    case (state)
      PRESSED:     tmr_limit = LONG_LIM;
      WAIT_SECOND: tmr_limit = DBL_LIM;
      LONG_HELD:   tmr_limit = REPEAT_LIM;
      default:     tmr_limit = '0;
    endcase
  end

  key_gesture_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .limit (tmr_limit),
    .term  (term)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register (outputs registered alongside)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      short_r <= 1'b0;
      long_r  <= 1'b0;
      dbl_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state   <= state_nxt;
      short_r <= short_nxt;
      long_r  <= long_nxt;
      dbl_r   <= dbl_nxt;
      busy_r  <= (state_nxt != IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. Key events take priority over a timer expiry on
  // the same edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (down) state_nxt = PRESSED;
      end
      PRESSED: begin
        if (up)        state_nxt = WAIT_SECOND;
        else if (term) state_nxt = LONG_HELD;
      end
      LONG_HELD: begin
        if (up) state_nxt = IDLE;
      end
      WAIT_SECOND: begin
        if (down)      state_nxt = SECOND_PRESSED;
        else if (term) state_nxt = IDLE;
      end
      SECOND_PRESSED: begin
        if (up) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (next pulse values and timer control). The timer is
  // cleared on every state change so each state starts timing from 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    short_nxt = 1'b0;
    long_nxt  = 1'b0;
    dbl_nxt   = 1'b0;
    tmr_clr   = (state_nxt != state);
    tmr_en    = 1'b0;
    case (state)
      PRESSED: begin
        long_nxt = ~up & term;
        tmr_en   = ~up & ~term;
      end
      WAIT_SECOND: begin
        short_nxt = ~down & term;
        tmr_en    = ~down & ~term;
      end
      SECOND_PRESSED: begin
        dbl_nxt = up;
      end
`ifdef KEY_REPEAT_EN
      LONG_HELD: begin
        tmr_en = ~up & ~term;
        // Restart the period after each repeat pulse.
        if (~up & term) tmr_clr = 1'b1;
      end
`endif
      default: begin
        short_nxt = 1'b0;
      end
    endcase
  end

`ifdef KEY_REPEAT_EN
  logic repeat_r;

  // Release on the period boundary suppresses the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      repeat_r <= 1'b0;
    end else begin
      repeat_r <= (state == LONG_HELD) & ~up & term;
    end
  end

  assign bus.out_repeat = repeat_r;
`else
  assign bus.out_repeat = 1'b0;
`endif

  assign bus.out_short_press  = short_r;
  assign bus.out_long_press   = long_r;
  assign bus.out_double_click = dbl_r;
  assign bus.out_busy         = busy_r;

endmodule
`default_nettype wire

// File: tb/tb_key_press_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_key_press_decoder                                         |
// | Description : Self-checking bench for key_press_decoder (LONG_CYC=20,      |
// |               DBL_CYC=10, REPEAT_CYC=5). Expected pulses (kind, edge) are  |
// |               queued with the stimulus and matched as pulses appear.      |
// |               Optional KEY_REPEAT_EN scenario enabled with the macro.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_key_press_decoder;
  localparam int LONG_CYC   = 20;
  localparam int DBL_CYC    = 10;
  localparam int REPEAT_CYC = 5;
  localparam int CNT_W      = 8;

  localparam int K_SHORT  = 0;
  localparam int K_LONG   = 1;
  localparam int K_DBL    = 2;
  localparam int K_REPEAT = 3;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  exp_t exp_q[$];

  int   mon_np;
  int   mon_kind;
  exp_t mon_e;

  key_press_decoder_if kif ();

  key_press_decoder #(
    .LONG_CYC   (LONG_CYC),
    .DBL_CYC    (DBL_CYC),
    .REPEAT_CYC (REPEAT_CYC),
    .CNT_W      (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Pulse monitor / scoreboard: cyc at a negedge equals the number of the
  // rising edge that produced the visible output.
  always @(negedge clk) begin
    mon_np = int'(kif.out_short_press) + int'(kif.out_long_press) +
             int'(kif.out_double_click) + int'(kif.out_repeat);
    if (rst_n && mon_np != 0) begin
      if (mon_np > 1) begin
        n_cmp++;
        n_bad++;
        $display("FAIL onehot: %0d pulses high at cycle %0d, required at most 1", mon_np, cyc);
      end
      mon_kind = kif.out_short_press ? K_SHORT :
                 kif.out_long_press  ? K_LONG  :
                 kif.out_double_click ? K_DBL : K_REPEAT;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: kind %0d at cycle %0d, required none", mon_kind, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.kind !== mon_kind || mon_e.cyc !== cyc) begin
          n_bad++;
          $display("FAIL pulse: kind %0d at cycle %0d, required kind %0d at cycle %0d",
                   mon_kind, cyc, mon_e.kind, mon_e.cyc);
        end
      end
    end
  end

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Drive an event so that rising edge number 'edge_n' samples it.
  task automatic drive_at(input int edge_n, input logic dn, input logic upv);
    wait_until(edge_n - 1);
    kif.in_key_down = dn;
    kif.in_key_up   = upv;
    @(negedge clk);
    kif.in_key_down = 1'b0;
    kif.in_key_up   = 1'b0;
  endtask

  task automatic expect_pulse(input int kind, input int at);
    exp_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    logic [4:0] outs;
    rst_n = 1'b0;
    kif.in_key_down = 1'b0;
    kif.in_key_up   = 1'b0;
    repeat (3) @(negedge clk);
    outs = {kif.out_short_press, kif.out_long_press, kif.out_double_click,
            kif.out_repeat, kif.out_busy};
    n_cmp++;
    if (outs !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b, required 00000", outs);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (kif.out_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle_busy: got %b, required 0", kif.out_busy);
    end
  endtask

  task automatic test_short_press();
    int e0;
    e0 = cyc + 2;
    drive_at(e0, 1'b1, 1'b0);
    n_cmp++;
    if (kif.out_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL short_busy_pressed: got %b, required 1", kif.out_busy);
    end
    drive_at(e0 + 5, 1'b0, 1'b1);
    expect_pulse(K_SHORT, e0 + 5 + DBL_CYC);
    wait_until(e0 + 5 + DBL_CYC + 8);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL short_missing: %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    n_cmp++;
    if (kif.out_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL short_busy_after: got %b, required 0", kif.out_busy);
    end
  endtask

  task automatic test_long_press();
    int e0;
    e0 = cyc + 2;
    drive_at(e0, 1'b1, 1'b0);
    expect_pulse(K_LONG, e0 + LONG_CYC);
`ifdef KEY_REPEAT_EN
    expect_pulse(K_REPEAT, e0 + LONG_CYC + REPEAT_CYC);
`endif
    wait_until(e0 + 27);
    n_cmp++;
    if (kif.out_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL long_busy_held: got %b, required 1", kif.out_busy);
    end
    drive_at(e0 + 30, 1'b0, 1'b1);
    n_cmp++;
    if (kif.out_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL long_busy_release: got %b, required 0", kif.out_busy);
    end
    wait_until(e0 + 50);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL long_missing: %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_double_click();
    int e0;
    e0 = cyc + 2;
    drive_at(e0, 1'b1, 1'b0);
    drive_at(e0 + 3, 1'b0, 1'b1);
    drive_at(e0 + 7, 1'b1, 1'b0);
    expect_pulse(K_DBL, e0 + 9);
    drive_at(e0 + 9, 1'b0, 1'b1);
    wait_until(e0 + 30);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL double_missing: %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    n_cmp++;
    if (kif.out_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL double_busy_after: got %b, required 0", kif.out_busy);
    end
  endtask

  // Release on the very edge the long count terminates: release wins.
  task automatic test_long_terminal_race();
    int e0;
    e0 = cyc + 2;
    drive_at(e0, 1'b1, 1'b0);
    drive_at(e0 + LONG_CYC, 1'b0, 1'b1);
    expect_pulse(K_SHORT, e0 + LONG_CYC + DBL_CYC);
    wait_until(e0 + LONG_CYC + DBL_CYC + 8);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL long_race_missing: %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Second press on the very edge the double-click window expires.
  task automatic test_double_timeout_race();
    int e0;
    e0 = cyc + 2;
    drive_at(e0, 1'b1, 1'b0);
    drive_at(e0 + 3, 1'b0, 1'b1);
    drive_at(e0 + 3 + DBL_CYC, 1'b1, 1'b0);
    expect_pulse(K_DBL, e0 + 3 + DBL_CYC + 2);
    drive_at(e0 + 3 + DBL_CYC + 2, 1'b0, 1'b1);
    wait_until(e0 + 40);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL dbl_race_missing: %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_gesture();
    int e0;
    logic [4:0] outs;
    e0 = cyc + 2;
    drive_at(e0, 1'b1, 1'b0);
    drive_at(e0 + 3, 1'b0, 1'b1);
    wait_until(e0 + 6);
    n_cmp++;
    if (kif.out_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_busy_before: got %b, required 1", kif.out_busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    outs = {kif.out_short_press, kif.out_long_press, kif.out_double_click,
            kif.out_repeat, kif.out_busy};
    n_cmp++;
    if (outs !== 5'b0) begin
      n_bad++;
      $display("FAIL rst_mid_async: got %b, required 00000", outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_until(cyc + 2 * DBL_CYC);
    n_cmp++;
    if (kif.out_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_busy_after: got %b, required 0", kif.out_busy);
    end
  endtask

  task automatic test_simultaneous_noop();
    int e0;
    e0 = cyc + 2;
    drive_at(e0, 1'b1, 1'b1);
    wait_until(e0 + 3);
    n_cmp++;
    if (kif.out_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL noop_idle_busy: got %b, required 0", kif.out_busy);
    end
    drive_at(e0 + 5, 1'b1, 1'b0);
    drive_at(e0 + 10, 1'b1, 1'b1);
    n_cmp++;
    if (kif.out_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL noop_pressed_busy: got %b, required 1", kif.out_busy);
    end
    drive_at(e0 + 13, 1'b0, 1'b1);
    expect_pulse(K_SHORT, e0 + 13 + DBL_CYC);
    wait_until(e0 + 13 + DBL_CYC + 6);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL noop_missing: %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // A new press on the edge right after a short pulse starts a fresh gesture.
  task automatic test_back_to_back();
    int e0;
    int e1;
    e0 = cyc + 2;
    drive_at(e0, 1'b1, 1'b0);
    drive_at(e0 + 2, 1'b0, 1'b1);
    expect_pulse(K_SHORT, e0 + 2 + DBL_CYC);
    e1 = e0 + 3 + DBL_CYC;
    drive_at(e1, 1'b1, 1'b0);
    n_cmp++;
    if (kif.out_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_busy_second: got %b, required 1", kif.out_busy);
    end
    drive_at(e1 + 2, 1'b0, 1'b1);
    expect_pulse(K_SHORT, e1 + 2 + DBL_CYC);
    wait_until(e1 + 2 + DBL_CYC + 6);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_missing: %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

`ifdef KEY_REPEAT_EN
  task automatic test_repeat();
    int e0;
    e0 = cyc + 2;
    drive_at(e0, 1'b1, 1'b0);
    expect_pulse(K_LONG, e0 + LONG_CYC);
    for (int i = 1; i <= 3; i++) expect_pulse(K_REPEAT, e0 + LONG_CYC + i * REPEAT_CYC);
    drive_at(e0 + 2 * LONG_CYC, 1'b0, 1'b1);
    wait_until(e0 + 2 * LONG_CYC + 20);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL repeat_missing: %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    kif.in_key_down = 1'b0;
    kif.in_key_up   = 1'b0;
    @(negedge clk);
    test_reset();
    test_short_press();
    test_long_press();
    test_double_click();
    test_long_terminal_race();
    test_double_timeout_race();
    test_reset_mid_gesture();
    test_simultaneous_noop();
    test_back_to_back();
`ifdef KEY_REPEAT_EN
    test_repeat();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
